// File: rtl/router_fsm_n_if.sv
// router_fsm_n_if: bundle between the router input stage, output FIFOs and the control FSM.
// Latency: none, wires only.
// Backpressure: busy, driven by the FSM, stalls the byte source.
//
// Port summary (slave = FSM side):
//   in : data_in[ADDR_W]    header address bits of the current byte
//        pkt_valid          source packet-valid
//        parity_done        parity byte accepted by the register block
//        low_pkt_valid      pkt_valid fell while the FIFO was full
//        fifo_full          full flag of the selected FIFO
//        fifo_empty[NUM_PORTS] / soft_reset[NUM_PORTS]  per-port status
//        wait_limit[TMO_W]  WAIT timeout in cycles, 0 = never time out
//   out: addr_out, state decodes, write_enb_reg, busy, pkt_drop
interface router_fsm_n_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TMO_W     = 6
);
    logic [ADDR_W-1:0]    data_in;
    logic                 pkt_valid;
    logic                 parity_done;
    logic                 low_pkt_valid;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] soft_reset;
    logic [TMO_W-1:0]     wait_limit;

    logic [ADDR_W-1:0]    addr_out;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 full_state;
    logic                 laf_state;
    logic                 rst_int_reg;
    logic                 drop_state;
    logic                 write_enb_reg;
    logic                 busy;
    logic                 pkt_drop;

    modport master (
        output data_in, pkt_valid, parity_done, low_pkt_valid, fifo_full,
               fifo_empty, soft_reset, wait_limit,
        input  addr_out, detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, drop_state, write_enb_reg, busy, pkt_drop
    );

    modport slave (
        input  data_in, pkt_valid, parity_done, low_pkt_valid, fifo_full,
               fifo_empty, soft_reset, wait_limit,
        output addr_out, detect_add, lfd_state, ld_state, full_state, laf_state,
               rst_int_reg, drop_state, write_enb_reg, busy, pkt_drop
    );
endinterface

// File: rtl/router_fsm_n.sv
// router_fsm_n: packet-router control FSM for NUM_PORTS outputs (decode, load, full, parity, drop).
// Latency: all outputs registered; header in DECODE at cycle 0 gives LFD at 1 and first write at 2.
// Backpressure: busy stalls the source in LFD/FULL/LAF/LP/CPE/WAIT; DROP swallows bytes unwritten.
//
// Ports: clk, resetn (synchronous, active-low), bus (router_fsm_n_if.slave) carrying the
// header address, packet/FIFO status, per-port soft resets, WAIT timeout limit, and the
// registered state decodes, write enable, busy, pkt_drop pulse and latched destination.
module router_fsm_n #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 2,
    parameter int TMO_W     = 6
) (
    input  logic          clk,
    input  logic          resetn,
    router_fsm_n_if.slave bus
);
    typedef enum logic [3:0] {
        S_DECODE = 4'd0,
        S_LFD    = 4'd1,
        S_LD     = 4'd2,
        S_FULL   = 4'd3,
        S_LAF    = 4'd4,
        S_LP     = 4'd5,
        S_CPE    = 4'd6,
        S_WAIT   = 4'd7,
        S_DROP   = 4'd8
    } state_t;

    localparam int              NSEL   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] NP_VAL = (ADDR_W+1)'(NUM_PORTS);

    state_t            r_state;
    state_t            w_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [TMO_W-1:0]  r_tmr;

    logic r_detect_add, r_lfd_state, r_ld_state, r_full_state, r_laf_state;
    logic r_rst_int_reg, r_drop_state, r_write_enb_reg, r_busy, r_pkt_drop;

    // Status vectors widened to the full address space so any address can index
    // them; ports that do not exist read as not-empty / no soft reset.
    logic [NSEL-1:0] w_empty_pad;
    logic [NSEL-1:0] w_srst_pad;

    for (genvar g = 0; g < NSEL; g++) begin : g_pad
        if (g < NUM_PORTS) begin : g_real
            assign w_empty_pad[g] = bus.fifo_empty[g];
            assign w_srst_pad[g]  = bus.soft_reset[g];
        end else begin : g_none
            assign w_empty_pad[g] = 1'b0;
            assign w_srst_pad[g]  = 1'b0;
        end
    end

    logic             w_in_range;
    logic             w_hdr_empty;
    logic             w_sel_empty;
    logic             w_srst_act;
    logic             w_tmo;
    logic [TMO_W-1:0] w_lim_m1;

    assign w_in_range  = ({1'b0, bus.data_in} < NP_VAL);
    assign w_hdr_empty = w_empty_pad[bus.data_in];
    assign w_sel_empty = w_empty_pad[r_addr];
    // Soft reset only matters while a packet for the selected port is in flight.
    assign w_srst_act  = w_srst_pad[r_addr] && (r_state != S_DECODE) && (r_state != S_DROP);
    assign w_lim_m1    = bus.wait_limit - TMO_W'(1);
    // Timer reads k in the k-th WAIT cycle after entry, so limit L leaves WAIT after L cycles.
    assign w_tmo       = (bus.wait_limit != '0) && (r_tmr == w_lim_m1);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_DECODE: begin
                if (bus.pkt_valid) begin
                    if (!w_in_range)      w_nxt = S_DROP;
                    else if (w_hdr_empty) w_nxt = S_LFD;
                    else                  w_nxt = S_WAIT;
                end
            end
            S_LFD:  w_nxt = S_LD;
            S_LD: begin
                if (bus.fifo_full)       w_nxt = S_FULL;
                else if (!bus.pkt_valid) w_nxt = S_LP;
            end
            S_FULL: if (!bus.fifo_full) w_nxt = S_LAF;
            S_LAF: begin
                if (bus.parity_done)        w_nxt = S_DECODE;
                else if (bus.low_pkt_valid) w_nxt = S_LP;
                else                        w_nxt = S_LD;
            end
            S_LP:   w_nxt = S_CPE;
            S_CPE:  w_nxt = bus.fifo_full ? S_FULL : S_DECODE;
            S_WAIT: begin
                if (w_sel_empty) w_nxt = S_LFD;
                else if (w_tmo)  w_nxt = S_DROP;
            end
            S_DROP: if (!bus.pkt_valid) w_nxt = S_DECODE;
            default: w_nxt = S_DECODE;
        endcase
        // Remaining bytes of a soft-reset packet are swallowed in DROP.
        if (w_srst_act) w_nxt = bus.pkt_valid ? S_DROP : S_DECODE;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= S_DECODE;
            r_addr          <= '0;
            r_tmr           <= '0;
            r_detect_add    <= 1'b1;
            r_lfd_state     <= 1'b0;
            r_ld_state      <= 1'b0;
            r_full_state    <= 1'b0;
            r_laf_state     <= 1'b0;
            r_rst_int_reg   <= 1'b0;
            r_drop_state    <= 1'b0;
            r_write_enb_reg <= 1'b0;
            r_busy          <= 1'b0;
            r_pkt_drop      <= 1'b0;
        end else begin
            r_state <= w_nxt;

            if (w_srst_act)
                r_addr <= '0;
            else if ((r_state == S_DECODE) && bus.pkt_valid && w_in_range)
                r_addr <= bus.data_in;

            if ((r_state == S_WAIT) && (w_nxt == S_WAIT)) begin
                if (r_tmr != '1) r_tmr <= r_tmr + TMO_W'(1);
            end else begin
                r_tmr <= '0;
            end

            // Moore decodes of the next state, registered so they line up with r_state.
            r_detect_add    <= (w_nxt == S_DECODE);
            r_lfd_state     <= (w_nxt == S_LFD);
            r_ld_state      <= (w_nxt == S_LD);
            r_full_state    <= (w_nxt == S_FULL);
            r_laf_state     <= (w_nxt == S_LAF);
            r_rst_int_reg   <= (w_nxt == S_CPE);
            r_drop_state    <= (w_nxt == S_DROP);
            r_write_enb_reg <= (w_nxt == S_LD) || (w_nxt == S_LAF) || (w_nxt == S_LP);
            r_busy          <= (w_nxt == S_LFD) || (w_nxt == S_FULL) || (w_nxt == S_LAF) ||
                               (w_nxt == S_LP) || (w_nxt == S_CPE) || (w_nxt == S_WAIT);
            r_pkt_drop      <= (w_nxt == S_DROP) && (r_state != S_DROP);
        end
    end

    assign bus.addr_out      = r_addr;
    assign bus.detect_add    = r_detect_add;
    assign bus.lfd_state     = r_lfd_state;
    assign bus.ld_state      = r_ld_state;
    assign bus.full_state    = r_full_state;
    assign bus.laf_state     = r_laf_state;
    assign bus.rst_int_reg   = r_rst_int_reg;
    assign bus.drop_state    = r_drop_state;
    assign bus.write_enb_reg = r_write_enb_reg;
    assign bus.busy          = r_busy;
    assign bus.pkt_drop      = r_pkt_drop;
endmodule

// File: tb/tb_router_fsm_n.sv
// tb_router_fsm_n: packet-level bench for router_fsm_n; each scenario predicts its phase trace.
// Latency: checks every cycle, 1 time unit after the rising edge, then drives that cycle's inputs.
// Backpressure: n/a; the bench plays the source, FIFOs and register block.
module tb_router_fsm_n;
    localparam int NP = 3;
    localparam int AW = 2;
    localparam int TW = 6;

    localparam int P_DEC  = 0;
    localparam int P_LFD  = 1;
    localparam int P_LD   = 2;
    localparam int P_FULL = 3;
    localparam int P_LAF  = 4;
    localparam int P_LP   = 5;
    localparam int P_CPE  = 6;
    localparam int P_WAIT = 7;
    localparam int P_DROP = 8;

    logic clk = 1'b0;
    logic resetn;

    router_fsm_n_if #(.NUM_PORTS(NP), .ADDR_W(AW), .TMO_W(TW)) bus();

    router_fsm_n #(.NUM_PORTS(NP), .ADDR_W(AW), .TMO_W(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int            n_cmp  = 0;
    int            n_fail = 0;
    int            m_prev;
    logic [AW-1:0] m_addr;

    // Expected {detect_add, lfd, ld, full, laf, rst_int, drop, write_enb, busy} per phase.
    function automatic logic [8:0] dec_of(input int ph);
        logic web;
        logic bsy;
        web = (ph == P_LD) || (ph == P_LAF) || (ph == P_LP);
        bsy = (ph == P_LFD) || (ph == P_FULL) || (ph == P_LAF) ||
              (ph == P_LP) || (ph == P_CPE) || (ph == P_WAIT);
        return {ph == P_DEC, ph == P_LFD, ph == P_LD, ph == P_FULL, ph == P_LAF,
                ph == P_CPE, ph == P_DROP, web, bsy};
    endfunction

    function automatic logic [NP-1:0] sel(input int a);
        return NP'(1) << a;
    endfunction

    // Check the cycle's expected phase, then load default (mostly random, harmless) inputs.
    task automatic cyc(input int ph);
        logic [8:0] obs;
        logic [8:0] expv;
        logic       exp_pd;
        @(posedge clk);
        #1;
        obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.full_state, bus.laf_state,
               bus.rst_int_reg, bus.drop_state, bus.write_enb_reg, bus.busy};
        expv   = dec_of(ph);
        exp_pd = (ph == P_DROP) && (m_prev != P_DROP);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL decodes t=%0t phase=%0d observed=%b expected=%b", $time, ph, obs, expv);
        end
        n_cmp++;
        assert (bus.pkt_drop === exp_pd) else begin
            n_fail++;
            $error("FAIL pkt_drop t=%0t phase=%0d observed=%b expected=%b", $time, ph, bus.pkt_drop, exp_pd);
        end
        n_cmp++;
        assert (bus.addr_out === m_addr) else begin
            n_fail++;
            $error("FAIL addr_out t=%0t phase=%0d observed=%0d expected=%0d", $time, ph, bus.addr_out, m_addr);
        end
        m_prev = ph;
        resetn            = 1'b1;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = AW'($urandom);
        bus.fifo_full     = 1'b0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_empty    = NP'($urandom);
        bus.soft_reset    = NP'($urandom) & ~sel(int'(m_addr));
    endtask

    task automatic hdr_go(input int a, input logic empty);
        bus.pkt_valid = 1'b1;
        bus.data_in   = AW'(a);
        if (a < NP) begin
            bus.fifo_empty[a] = empty;
            m_addr = AW'(a);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(P_DEC);
    endtask

    // n LD cycles, pkt_valid falling in the last; optional full in CPE loops via FULL/LAF.
    task automatic pkt_normal(input int a, input int n, input bit cpe_full);
        cyc(P_DEC); hdr_go(a, 1'b1);
        cyc(P_LFD); bus.pkt_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc(P_LD); bus.pkt_valid = (i < n - 1);
        end
        cyc(P_LP);
        cyc(P_CPE);
        if (cpe_full) begin
            bus.fifo_full = 1'b1;
            cyc(P_FULL);
            cyc(P_LAF); bus.parity_done = 1'b1;
        end
    endtask

    task automatic pkt_bad(input int a, input int k);
        cyc(P_DEC); hdr_go(a, 1'b1);
        for (int i = 0; i < k; i++) begin
            cyc(P_DROP); bus.pkt_valid = (i < k - 1);
        end
    endtask

    // mode 0: never empties, times out after L WAIT cycles; mode 1: empties in WAIT cycle m.
    task automatic pkt_wait(input int a, input int lim, input int mode, input int m);
        bus.wait_limit = TW'(lim);
        cyc(P_DEC); hdr_go(a, 1'b0);
        if (mode == 0) begin
            for (int i = 0; i < lim; i++) begin
                cyc(P_WAIT); bus.pkt_valid = 1'b1; bus.fifo_empty[a] = 1'b0;
            end
            cyc(P_DROP); bus.pkt_valid = 1'b1;
            cyc(P_DROP);
        end else begin
            for (int i = 0; i < m; i++) begin
                cyc(P_WAIT); bus.pkt_valid = 1'b1; bus.fifo_empty[a] = (i == m - 1);
            end
            cyc(P_LFD); bus.pkt_valid = 1'b1;
            cyc(P_LD);
            cyc(P_LP);
            cyc(P_CPE);
        end
    endtask

    // Full for f cycles from an LD cycle; LAF exit 0: low_pkt_valid, 1: parity_done, 2: neither.
    task automatic pkt_full(input int a, input int pre, input int f, input int mode, input bit pv_lo);
        cyc(P_DEC); hdr_go(a, 1'b1);
        cyc(P_LFD); bus.pkt_valid = 1'b1;
        for (int i = 0; i < pre; i++) begin
            cyc(P_LD); bus.pkt_valid = 1'b1;
        end
        cyc(P_LD); bus.pkt_valid = !pv_lo; bus.fifo_full = 1'b1;
        for (int i = 0; i < f; i++) begin
            cyc(P_FULL); bus.fifo_full = (i < f - 1);
        end
        cyc(P_LAF);
        if (mode == 0) begin
            bus.low_pkt_valid = 1'b1;
            cyc(P_LP);
            cyc(P_CPE);
        end else if (mode == 1) begin
            bus.parity_done   = 1'b1;
            bus.low_pkt_valid = 1'($urandom);
        end else begin
            cyc(P_LD);
            cyc(P_LP);
            cyc(P_CPE);
        end
    endtask

    // Other ports' soft resets first (no effect), then the selected one in LD or FULL.
    task automatic pkt_srst(input int a, input int where, input bit pvr);
        cyc(P_DEC); hdr_go(a, 1'b1);
        cyc(P_LFD); bus.pkt_valid = 1'b1;
        cyc(P_LD); bus.pkt_valid = 1'b1; bus.soft_reset = ~sel(a);
        if (where == 1) begin
            cyc(P_LD); bus.pkt_valid = 1'b1; bus.fifo_full = 1'b1;
            cyc(P_FULL); bus.fifo_full = 1'b1;
        end else begin
            cyc(P_LD); bus.pkt_valid = 1'b1;
        end
        bus.soft_reset = '1;
        bus.pkt_valid  = pvr;
        m_addr = '0;
        if (pvr) cyc(P_DROP);
    endtask

    task automatic pkt_reset(input int a, input bit sr);
        cyc(P_DEC); hdr_go(a, 1'b1);
        cyc(P_LFD); bus.pkt_valid = 1'b1;
        cyc(P_LD); bus.pkt_valid = 1'b1; bus.fifo_full = 1'b1;
        cyc(P_FULL); bus.fifo_full = 1'b1;
        resetn = 1'b0;
        if (sr) bus.soft_reset[a] = 1'b1;
        bus.pkt_valid = 1'($urandom);
        m_addr = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        int a;
        int lim;
        int m;
        resetn            = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.data_in       = '0;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty    = '1;
        bus.soft_reset    = '1;
        bus.wait_limit    = '0;
        m_addr = '0;
        m_prev = P_DEC;

        cyc(P_DEC); resetn = 1'b0; bus.pkt_valid = 1'b1;
        idle(3);

        pkt_normal(1, 4, 1'b0);
        pkt_bad(3, 6);
        pkt_wait(2, 5, 0, 0);
        pkt_wait(2, 5, 1, 3);
        pkt_wait(1, 4, 1, 4);
        pkt_wait(2, 0, 1, 100);
        pkt_full(1, 1, 3, 0, 1'b0);
        pkt_full(1, 1, 3, 1, 1'b0);
        pkt_full(2, 0, 2, 2, 1'b1);
        pkt_normal(0, 2, 1'b1);
        pkt_srst(1, 0, 1'b1);
        pkt_srst(2, 1, 1'b0);
        pkt_srst(1, 1, 1'b1);
        pkt_reset(1, 1'b0);
        pkt_reset(2, 1'b1);

        for (int it = 0; it < 60; it++) begin
            sc = $urandom_range(0, 6);
            a  = $urandom_range(0, NP - 1);
            case (sc)
                0: pkt_normal(a, $urandom_range(1, 6), 1'($urandom));
                1: pkt_bad($urandom_range(NP, (1 << AW) - 1), $urandom_range(1, 5));
                2: pkt_wait(a, $urandom_range(1, 9), 0, 0);
                3: begin
                    lim = $urandom_range(0, 9);
                    m   = (lim == 0) ? $urandom_range(1, 12) : $urandom_range(1, lim);
                    pkt_wait(a, lim, 1, m);
                end
                4: pkt_full(a, $urandom_range(0, 3), $urandom_range(1, 4),
                            $urandom_range(0, 2), 1'($urandom));
                5: pkt_srst(a, $urandom_range(0, 1), 1'($urandom));
                default: pkt_reset(a, 1'($urandom));
            endcase
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
